// File: rtl/fetch_sequencer.sv
// Control sequencer that owns the program counter and steps the datapath through
// fetch, decode, execute and writeback, honouring memory stalls, branches and halts.
module fetch_sequencer #(
   parameter int unsigned           PC_WIDTH  = 8,
   parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
   parameter int unsigned           CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 stall,
   input  logic                 halt_req,
   input  logic                 branch_taken,
   input  logic [PC_WIDTH-1:0]  branch_target,
   output logic [PC_WIDTH-1:0]  pc_counter,
   output logic                 fetch_en,
   output logic                 decode_en,
   output logic                 exec_en,
   output logic                 wb_en,
   output logic                 running,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] retired_count
);

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExecute,
      StWriteback,
      StHalted
   } state_e;

   state_e                 state_q, state_d;
   logic [PC_WIDTH-1:0]    pc_q, pc_d;
   logic [PC_WIDTH-1:0]    br_tgt_q, br_tgt_d;
   logic                   br_pend_q, br_pend_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pc_q      <= RESET_PC;
         br_tgt_q  <= '0;
         br_pend_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         br_tgt_q  <= br_tgt_d;
         br_pend_q <= br_pend_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      br_tgt_d  = br_tgt_q;
      br_pend_d = br_pend_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         StIdle, StHalted: begin
            if (start) begin
               state_d   = StFetch;
               pc_d      = RESET_PC;
               cnt_d     = '0;
               br_pend_d = 1'b0;
            end
         end
         StFetch: begin
            if (!stall) state_d = StDecode;
         end
         StDecode: begin
            state_d = StExecute;
         end
         StExecute: begin
            state_d   = StWriteback;
            br_pend_d = branch_taken;
            br_tgt_d  = branch_target;
         end
         StWriteback: begin
            // A pending branch is committed even when halting.
            state_d   = halt_req ? StHalted : StFetch;
            pc_d      = br_pend_q ? br_tgt_q : pc_q + 1'b1;
            br_pend_d = 1'b0;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign pc_counter    = pc_q;
   assign retired_count = cnt_q;
   assign fetch_en      = (state_q == StFetch);
   assign decode_en     = (state_q == StDecode);
   assign exec_en       = (state_q == StExecute);
   assign wb_en         = (state_q == StWriteback);
   assign running       = fetch_en | decode_en | exec_en | wb_en;
   assign halted        = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer plus hand sequences for
// async reset, restart and counter saturation (second instance with CNT_WIDTH=4).
module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        halt_req = 1'b0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = '0;

   logic [7:0]  pc_counter;
   logic        fetch_en, decode_en, exec_en, wb_en, running, halted;
   logic [15:0] retired_count;

   logic [7:0]  s_pc;
   logic        s_fetch, s_decode, s_exec, s_wb, s_running, s_halted;
   logic [3:0]  s_count;

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .stall         (stall),
      .halt_req      (halt_req),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc_counter    (pc_counter),
      .fetch_en      (fetch_en),
      .decode_en     (decode_en),
      .exec_en       (exec_en),
      .wb_en         (wb_en),
      .running       (running),
      .halted        (halted),
      .retired_count (retired_count)
   );

   fetch_sequencer #(.CNT_WIDTH(4)) dut_sat (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .stall         (stall),
      .halt_req      (halt_req),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc_counter    (s_pc),
      .fetch_en      (s_fetch),
      .decode_en     (s_decode),
      .exec_en       (s_exec),
      .wb_en         (s_wb),
      .running       (s_running),
      .halted        (s_halted),
      .retired_count (s_count)
   );

   // en = {fetch, decode, exec, wb, running, halted}
   localparam logic [5:0] EnI = 6'b000000;
   localparam logic [5:0] EnF = 6'b100010;
   localparam logic [5:0] EnD = 6'b010010;
   localparam logic [5:0] EnE = 6'b001010;
   localparam logic [5:0] EnW = 6'b000110;
   localparam logic [5:0] EnH = 6'b000001;

   typedef struct packed {
      logic        start;
      logic        stall;
      logic        halt;
      logic        br;
      logic [7:0]  tgt;
      logic [5:0]  en;
      logic [7:0]  pc;
      logic [15:0] cnt;
   } vec_t;

   vec_t tbl[$];
   int   nvec = 0;
   int   nmis = 0;

   function automatic vec_t mk(input logic s, input logic st, input logic h, input logic b,
                               input logic [7:0] t, input logic [5:0] e, input logic [7:0] p,
                               input logic [15:0] c);
      vec_t v;
      v.start = s; v.stall = st; v.halt = h; v.br = b; v.tgt = t;
      v.en = e; v.pc = p; v.cnt = c;
      return v;
   endfunction

   task automatic check(input string name, input logic [5:0] e, input logic [7:0] p,
                        input logic [15:0] c);
      logic [5:0] got;
      got = {fetch_en, decode_en, exec_en, wb_en, running, halted};
      nvec++;
      if (got !== e || pc_counter !== p || retired_count !== c) begin
         nmis++;
         $display("FAIL %s: got en=%b pc=%h cnt=%0d, want en=%b pc=%h cnt=%0d",
                  name, got, pc_counter, retired_count, e, p, c);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Inputs of each row are sampled at the edge that produces its expected outputs.
      tbl.push_back(mk(0,0,0,0,8'h00, EnI, 8'h00, 0));  // 0 idle without start
      tbl.push_back(mk(1,0,0,0,8'h00, EnF, 8'h00, 0));  // 1 start
      tbl.push_back(mk(0,0,0,0,8'h00, EnD, 8'h00, 0));
      tbl.push_back(mk(0,0,0,0,8'h00, EnE, 8'h00, 0));
      tbl.push_back(mk(0,0,0,0,8'h00, EnW, 8'h00, 0));
      tbl.push_back(mk(0,0,0,0,8'h00, EnF, 8'h01, 1));  // 5
      tbl.push_back(mk(0,0,0,0,8'h00, EnD, 8'h01, 1));
      tbl.push_back(mk(0,0,0,0,8'h00, EnE, 8'h01, 1));
      tbl.push_back(mk(0,0,0,0,8'h00, EnW, 8'h01, 1));
      tbl.push_back(mk(0,0,0,0,8'h00, EnF, 8'h02, 2));  // 9 first fetch at pc=2
      tbl.push_back(mk(0,1,0,0,8'h00, EnF, 8'h02, 2));  // stall x3
      tbl.push_back(mk(0,1,0,0,8'h00, EnF, 8'h02, 2));
      tbl.push_back(mk(0,1,0,0,8'h00, EnF, 8'h02, 2));
      tbl.push_back(mk(0,0,0,0,8'h00, EnD, 8'h02, 2));
      tbl.push_back(mk(0,0,0,0,8'h00, EnE, 8'h02, 2));
      tbl.push_back(mk(0,0,0,0,8'h00, EnW, 8'h02, 2));
      tbl.push_back(mk(0,0,0,0,8'h00, EnF, 8'h03, 3));  // 16
      tbl.push_back(mk(0,0,0,0,8'h00, EnD, 8'h03, 3));
      tbl.push_back(mk(0,0,0,0,8'h00, EnE, 8'h03, 3));
      tbl.push_back(mk(0,0,0,0,8'h00, EnW, 8'h03, 3));
      tbl.push_back(mk(0,0,0,0,8'h00, EnF, 8'h04, 4));  // 20
      tbl.push_back(mk(0,0,0,0,8'h00, EnD, 8'h04, 4));
      tbl.push_back(mk(0,0,0,0,8'h00, EnE, 8'h04, 4));
      tbl.push_back(mk(0,0,0,0,8'h00, EnW, 8'h04, 4));
      tbl.push_back(mk(0,0,0,0,8'h00, EnF, 8'h05, 5));  // 24
      tbl.push_back(mk(0,0,0,0,8'h00, EnD, 8'h05, 5));
      tbl.push_back(mk(0,1,0,0,8'h00, EnE, 8'h05, 5));  // stall outside FETCH ignored
      tbl.push_back(mk(0,0,0,1,8'h40, EnW, 8'h05, 5));  // branch sampled in EXECUTE
      tbl.push_back(mk(0,0,0,0,8'h00, EnF, 8'h40, 6));  // 28
      tbl.push_back(mk(0,0,0,0,8'h00, EnD, 8'h40, 6));
      tbl.push_back(mk(0,0,0,1,8'h80, EnE, 8'h40, 6));  // branch during DECODE ignored
      tbl.push_back(mk(0,0,0,0,8'h00, EnW, 8'h40, 6));
      tbl.push_back(mk(0,0,0,0,8'h00, EnF, 8'h41, 7));  // 32
      tbl.push_back(mk(0,0,0,0,8'h00, EnD, 8'h41, 7));
      tbl.push_back(mk(0,0,0,0,8'h00, EnE, 8'h41, 7));
      tbl.push_back(mk(0,0,0,1,8'hFF, EnW, 8'h41, 7));
      tbl.push_back(mk(0,0,0,0,8'h00, EnF, 8'hFF, 8));  // 36
      tbl.push_back(mk(0,0,0,0,8'h00, EnD, 8'hFF, 8));
      tbl.push_back(mk(0,0,0,0,8'h00, EnE, 8'hFF, 8));
      tbl.push_back(mk(0,0,0,0,8'h00, EnW, 8'hFF, 8));
      tbl.push_back(mk(0,0,0,0,8'h00, EnF, 8'h00, 9));  // 40 wrap
      tbl.push_back(mk(0,0,1,0,8'h00, EnD, 8'h00, 9));  // halt in FETCH ignored
      tbl.push_back(mk(0,0,1,0,8'h00, EnE, 8'h00, 9));  // halt in DECODE ignored
      tbl.push_back(mk(0,0,0,1,8'h10, EnW, 8'h00, 9));
      tbl.push_back(mk(0,0,1,0,8'h00, EnH, 8'h10, 10)); // 44 halt + branch committed
      tbl.push_back(mk(0,0,0,0,8'h00, EnH, 8'h10, 10));
      tbl.push_back(mk(1,0,0,0,8'h00, EnF, 8'h00, 0));  // restart from HALTED
      tbl.push_back(mk(1,0,0,0,8'h00, EnD, 8'h00, 0));  // start while running ignored
      tbl.push_back(mk(0,0,0,0,8'h00, EnE, 8'h00, 0));
      tbl.push_back(mk(0,0,0,0,8'h00, EnW, 8'h00, 0));
      tbl.push_back(mk(0,0,0,0,8'h00, EnF, 8'h01, 1));  // 50

      repeat (2) @(posedge clk);
      #1;
      check("reset_hold", EnI, 8'h00, 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         start         = tbl[i].start;
         stall         = tbl[i].stall;
         halt_req      = tbl[i].halt;
         branch_taken  = tbl[i].br;
         branch_target = tbl[i].tgt;
         tick();
         check($sformatf("vec%0d", i), tbl[i].en, tbl[i].pc, tbl[i].cnt);
      end
      start = 0; stall = 0; halt_req = 0; branch_taken = 0; branch_target = '0;

      // Asynchronous reset in EXECUTE
      tick();
      tick();
      check("mid_exec", EnE, 8'h01, 1);
      rst_n = 1'b0;
      #2;
      check("async_reset", EnI, 8'h00, 0);
      rst_n = 1'b1;
      tick();
      check("post_release", EnI, 8'h00, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("restart_fetch", EnF, 8'h00, 0);
      repeat (3) tick();
      check("restart_wb", EnW, 8'h00, 0);
      tick();
      check("restart_next", EnF, 8'h01, 1);

      // 19 more instructions: 20 retired in total
      repeat (19 * 4) tick();
      check("run20", EnF, 8'h14, 20);
      nvec++;
      if (s_count !== 4'hF) begin
         nmis++;
         $display("FAIL sat_count: got %0d, want 15", s_count);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
